phase_freq_detector: RTL

- Sits directly downstream of the N-divider in the DPLL loop.
- Compares the rising edges of the external reference (ref_in) against the divided feedback clock (fb_in, the divider's out).
- Drives up/dn pulses to the loop filter and produces a signed per-comparison phase error, measured in clk cycles, with a one-cycle valid strobe.
- Both inputs are asynchronous to clk and are synchronized internally.

---
 rtl/dpll_pkg.sv | 17 +
 rtl/phase_freq_detector_edge_sync.sv | 27 ++
 rtl/phase_freq_detector.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared DPLL types and constants: PFD state encoding, default error width,
// and the signed saturation magnitude helper.
package dpll_pkg;

  localparam int unsigned ERR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    LAG
  } pfd_state_t;

  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/phase_freq_detector_edge_sync.sv
// Input synchronizer chain plus history flop; rise is a one-cycle pulse
// on each rising edge of the synchronized input.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/phase_freq_detector.sv
// Phase/frequency detector: up/dn pulses and signed per-comparison error in clk cycles.
// Optional lock detector built only when PFD_LOCK_DETECT_EN is defined.
module phase_freq_detector
  import dpll_pkg::*;
#(
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_CNT    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_valid,
  output logic                    locked
);

  localparam int unsigned            SAT     = sat_max(ERR_W);
  localparam logic [ERR_W-2:0]        CNT_MAX = SAT[ERR_W-2:0];
  localparam logic [ERR_W-2:0]        CNT_ONE = {{(ERR_W-2){1'b0}}, 1'b1};
  localparam logic signed [ERR_W-1:0] ERR_MAX = {1'b0, CNT_MAX};
  localparam logic signed [ERR_W-1:0] ERR_MIN = -ERR_MAX;

  if (SYNC_STAGES < 2 || LOCK_CNT < 1 || LOCK_TOL > SAT) begin : g_bad_cfg
    $error("phase_freq_detector: invalid parameter set");
  end

  logic ref_rise, fb_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(clk), .reset(reset), .din(ref_in), .rise(ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(clk), .reset(reset), .din(fb_in), .rise(fb_rise)
  );

  pfd_state_t                state;
  logic [ERR_W-2:0]          cnt;
  logic [ERR_W-2:0]          cnt_inc;
  logic signed [ERR_W-1:0]   cnt_pos;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign cnt_pos = $signed({1'b0, cnt});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      err       <= '0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        up    <= 1'b0;
        dn    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ref_rise && fb_rise) begin
              err       <= '0;
              err_valid <= 1'b1;
            end else if (ref_rise) begin
              state <= LEAD;
              cnt   <= CNT_ONE;
              up    <= 1'b1;
            end else if (fb_rise) begin
              state <= LAG;
              cnt   <= CNT_ONE;
              dn    <= 1'b1;
            end
          end
          LEAD: begin
            // A coincident pair closes this comparison and opens the next one.
            if (fb_rise) begin
              err       <= cnt_pos;
              err_valid <= 1'b1;
              if (ref_rise) begin
                cnt <= CNT_ONE;
              end else begin
                state <= IDLE;
                cnt   <= '0;
                up    <= 1'b0;
              end
            end else if (ref_rise) begin
              err       <= ERR_MAX;
              err_valid <= 1'b1;
              cnt       <= CNT_ONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          LAG: begin
            if (ref_rise) begin
              err       <= -cnt_pos;
              err_valid <= 1'b1;
              if (fb_rise) begin
                cnt <= CNT_ONE;
              end else begin
                state <= IDLE;
                cnt   <= '0;
                dn    <= 1'b0;
              end
            end else if (fb_rise) begin
              err       <= ERR_MIN;
              err_valid <= 1'b1;
              cnt       <= CNT_ONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            up    <= 1'b0;
            dn    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PFD_LOCK_DETECT_EN
  localparam int unsigned      LCW    = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0]   LIM    = LOCK_CNT[LCW-1:0];
  localparam logic [LCW-1:0]   LIM_M1 = LIM - 1'b1;
  localparam logic [ERR_W-1:0] TOL    = LOCK_TOL[ERR_W-1:0];

  logic [LCW-1:0]   lock_cnt;
  logic [ERR_W-1:0] err_abs;

  // err never reaches the most negative code, so negation cannot overflow.
  assign err_abs = err[ERR_W-1] ? -err : err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!enable) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (err_valid) begin
      if (err_abs <= TOL) begin
        if (lock_cnt != LIM) lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt >= LIM_M1) locked <= 1'b1;
      end else begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule
